// File: rtl/axil2wbm.sv
// AXI4-Lite slave to pipelined Wishbone master bridge: one transaction in flight at a time.
// Define AXIL2WBM_SKIDBUFFER_EN to give AW, W and AR a one-entry holding register each.
module axil2wbm #(
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int C_AXI_DATA_WIDTH = 32,
  localparam int DW  = C_AXI_DATA_WIDTH,
  localparam int LSB = $clog2(C_AXI_DATA_WIDTH / 8),
  localparam int AW  = C_AXI_ADDR_WIDTH - LSB
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_axi_awvalid,
  output logic                        o_axi_awready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_awaddr,
  input  logic                        i_axi_wvalid,
  output logic                        o_axi_wready,
  input  logic [DW-1:0]               i_axi_wdata,
  input  logic [DW/8-1:0]             i_axi_wstrb,
  output logic                        o_axi_bvalid,
  input  logic                        i_axi_bready,
  output logic [1:0]                  o_axi_bresp,
  input  logic                        i_axi_arvalid,
  output logic                        o_axi_arready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] i_axi_araddr,
  output logic                        o_axi_rvalid,
  input  logic                        i_axi_rready,
  output logic [DW-1:0]               o_axi_rdata,
  output logic [1:0]                  o_axi_rresp,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [AW-1:0]               o_wb_addr,
  output logic [DW-1:0]               o_wb_data,
  output logic [DW/8-1:0]             o_wb_sel,
  input  logic                        i_wb_stall,
  input  logic                        i_wb_ack,
  input  logic                        i_wb_err,
  input  logic [DW-1:0]               i_wb_data
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]                  state;
  logic                        last_write;
  logic                        wr_have, rd_have, grant_wr, grant_rd;
  logic [C_AXI_ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [DW-1:0]               wr_data;
  logic [DW/8-1:0]             wr_strb;

  // Byte-lane address bits are dropped by the word-address slice.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, i_axi_awaddr, i_axi_araddr};

`ifdef AXIL2WBM_SKIDBUFFER_EN
  logic                        aw_full, w_full, ar_full;
  logic [C_AXI_ADDR_WIDTH-1:0] aw_q, ar_q;
  logic [DW-1:0]               w_q;
  logic [DW/8-1:0]             ws_q;

  assign o_axi_awready = !aw_full;
  assign o_axi_wready  = !w_full;
  assign o_axi_arready = !ar_full;

  // A channel arriving on the granting cycle bypasses its entry, keeping latency.
  assign wr_have = (aw_full || i_axi_awvalid) && (w_full || i_axi_wvalid);
  assign rd_have = ar_full || i_axi_arvalid;
  assign wr_addr = aw_full ? aw_q : i_axi_awaddr;
  assign wr_data = w_full ? w_q : i_axi_wdata;
  assign wr_strb = w_full ? ws_q : i_axi_wstrb;
  assign rd_addr = ar_full ? ar_q : i_axi_araddr;

  // NOTE: only the full flags are reset; payload registers are qualified by them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
    end else begin
      if (grant_wr) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (i_axi_awvalid && !aw_full) begin
          aw_full <= 1'b1;
          aw_q    <= i_axi_awaddr;
        end
        if (i_axi_wvalid && !w_full) begin
          w_full <= 1'b1;
          w_q    <= i_axi_wdata;
          ws_q   <= i_axi_wstrb;
        end
      end
      if (grant_rd) begin
        ar_full <= 1'b0;
      end else if (i_axi_arvalid && !ar_full) begin
        ar_full <= 1'b1;
        ar_q    <= i_axi_araddr;
      end
    end
  end
`else
  assign wr_have = i_axi_awvalid && i_axi_wvalid;
  assign rd_have = i_axi_arvalid;
  assign wr_addr = i_axi_awaddr;
  assign wr_data = i_axi_wdata;
  assign wr_strb = i_axi_wstrb;
  assign rd_addr = i_axi_araddr;

  assign o_axi_awready = grant_wr;
  assign o_axi_wready  = grant_wr;
  assign o_axi_arready = grant_rd;
`endif

  // On a tie, the kind not granted last wins.
  assign grant_wr = (state == S_IDLE) && wr_have && (!rd_have || !last_write);
  assign grant_rd = (state == S_IDLE) && rd_have && (!wr_have || last_write);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= S_IDLE;
      last_write   <= 1'b1;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_we      <= 1'b0;
      o_wb_addr    <= '0;
      o_wb_data    <= '0;
      o_wb_sel     <= '0;
      o_axi_bvalid <= 1'b0;
      o_axi_bresp  <= 2'b00;
      o_axi_rvalid <= 1'b0;
      o_axi_rresp  <= 2'b00;
      o_axi_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_wr) begin
            state      <= S_BUS;
            last_write <= 1'b1;
            o_wb_cyc   <= 1'b1;
            o_wb_stb   <= 1'b1;
            o_wb_we    <= 1'b1;
            o_wb_addr  <= wr_addr[C_AXI_ADDR_WIDTH-1:LSB];
            o_wb_data  <= wr_data;
            o_wb_sel   <= wr_strb;
          end else if (grant_rd) begin
            state      <= S_BUS;
            last_write <= 1'b0;
            o_wb_cyc   <= 1'b1;
            o_wb_stb   <= 1'b1;
            o_wb_we    <= 1'b0;
            o_wb_addr  <= rd_addr[C_AXI_ADDR_WIDTH-1:LSB];
          end
        end
        S_BUS: begin
          if (o_wb_stb && !i_wb_stall) o_wb_stb <= 1'b0;
          // Completion may coincide with stb acceptance; err overrides ack.
          if (i_wb_ack || i_wb_err) begin
            state    <= S_RESP;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            if (o_wb_we) begin
              o_axi_bvalid <= 1'b1;
              o_axi_bresp  <= i_wb_err ? 2'b10 : 2'b00;
            end else begin
              o_axi_rvalid <= 1'b1;
              o_axi_rresp  <= i_wb_err ? 2'b10 : 2'b00;
              o_axi_rdata  <= i_wb_err ? '0 : i_wb_data;
            end
          end
        end
        S_RESP: begin
          if (o_axi_bvalid && i_axi_bready) begin
            o_axi_bvalid <= 1'b0;
            state        <= S_IDLE;
          end else if (o_axi_rvalid && i_axi_rready) begin
            o_axi_rvalid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil2wbm.sv
// Scoreboard bench for axil2wbm: directed AXI-Lite stimulus, a Wishbone slave model,
// and a monitor that checks Wishbone requests and AXI responses against queued expectations.
module tb_axil2wbm;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_axi_awvalid, o_axi_awready;
  logic [27:0] i_axi_awaddr;
  logic        i_axi_wvalid, o_axi_wready;
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        o_axi_bvalid, i_axi_bready;
  logic [1:0]  o_axi_bresp;
  logic        i_axi_arvalid, o_axi_arready;
  logic [27:0] i_axi_araddr;
  logic        o_axi_rvalid, i_axi_rready;
  logic [31:0] o_axi_rdata;
  logic [1:0]  o_axi_rresp;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [25:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack, i_wb_err;
  logic [31:0] i_wb_data;

  always #5 clk = ~clk;

  axil2wbm dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready), .i_axi_awaddr(i_axi_awaddr),
    .i_axi_wvalid(i_axi_wvalid), .o_axi_wready(o_axi_wready), .i_axi_wdata(i_axi_wdata),
    .i_axi_wstrb(i_axi_wstrb),
    .o_axi_bvalid(o_axi_bvalid), .i_axi_bready(i_axi_bready), .o_axi_bresp(o_axi_bresp),
    .i_axi_arvalid(i_axi_arvalid), .o_axi_arready(o_axi_arready), .i_axi_araddr(i_axi_araddr),
    .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready), .o_axi_rdata(o_axi_rdata),
    .o_axi_rresp(o_axi_rresp),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
  );

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t wb_q[$];
  exp_t rsp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout, expected the event within its cycle budget", name);
  endtask

  task automatic push_write(input logic [25:0] wa, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e = '{we: 1'b1, addr: wa, data: d, sel: s, resp: 2'b00, rdata: 32'h0};
    wb_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  task automatic push_read(input logic [25:0] wa, input logic [1:0] r, input logic [31:0] rd);
    exp_t e;
    e = '{we: 1'b0, addr: wa, data: 32'h0, sel: 4'h0, resp: r, rdata: rd};
    wb_q.push_back(e);
    rsp_q.push_back(e);
  endtask

  // Wishbone slave: stalls stall_cfg cycles per strobe, then acks/errs one cycle after acceptance.
  int          stall_cfg = 0;
  bit          slave_err = 1'b0;
  logic [31:0] slave_rdata = 32'h0;

  initial begin
    int stall_cnt;
    bit ack_next;
    stall_cnt  = 0;
    ack_next   = 1'b0;
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      i_wb_ack  = 1'b0;
      i_wb_err  = 1'b0;
      i_wb_data = 32'hBAD0_BAD0;
      if (ack_next) begin
        ack_next = 1'b0;
        if (slave_err) begin
          i_wb_err  = 1'b1;
          i_wb_data = 32'hFFFF_FFFF;
        end else begin
          i_wb_ack  = 1'b1;
          i_wb_data = slave_rdata;
        end
      end
      if (o_wb_cyc && o_wb_stb) begin
        if (stall_cnt < stall_cfg) begin
          i_wb_stall = 1'b1;
          stall_cnt++;
        end else begin
          i_wb_stall = 1'b0;
          stall_cnt  = 0;
          ack_next   = 1'b1;
        end
      end else begin
        i_wb_stall = 1'b0;
        stall_cnt  = 0;
      end
    end
  end

  // Monitor: samples late in the low phase, after all bench drivers have settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (o_wb_stb) check("stb_implies_cyc", o_wb_cyc, 1);
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        if (wb_q.size() == 0) begin
          timeout_fail("wb_unexpected_request");
        end else begin
          e = wb_q.pop_front();
          check("wb_we", o_wb_we, e.we);
          check("wb_addr", o_wb_addr, e.addr);
          if (e.we) begin
            check("wb_data", o_wb_data, e.data);
            check("wb_sel", o_wb_sel, e.sel);
          end
        end
      end
      if ((o_axi_bvalid && i_axi_bready) || (o_axi_rvalid && i_axi_rready)) begin
        if (rsp_q.size() == 0) begin
          timeout_fail("axi_unexpected_response");
        end else begin
          e = rsp_q.pop_front();
          check("resp_is_write", o_axi_bvalid, e.we);
          if (e.we) begin
            check("bresp", o_axi_bresp, e.resp);
          end else begin
            check("rresp", o_axi_rresp, e.resp);
            check("rdata", o_axi_rdata, e.rdata);
          end
        end
      end
    end
  end

  // Master tasks: called at a negedge (or just after), return at the negedge after the handshake.
  task automatic axi_write(input logic [27:0] a, input logic [31:0] d, input logic [3:0] s);
    int c;
    bit ok;
    c  = 0;
    ok = 1'b0;
    i_axi_awaddr  = a;
    i_axi_wdata   = d;
    i_axi_wstrb   = s;
    i_axi_awvalid = 1'b1;
    i_axi_wvalid  = 1'b1;
    while (!ok && c < 300) begin
      #1;
      if (o_axi_awready && o_axi_wready) ok = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    if (!ok) timeout_fail("aw_w_handshake");
    @(negedge clk);
    i_axi_awvalid = 1'b0;
    i_axi_wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [27:0] a);
    int c;
    bit ok;
    c  = 0;
    ok = 1'b0;
    i_axi_araddr  = a;
    i_axi_arvalid = 1'b1;
    while (!ok && c < 300) begin
      #1;
      if (o_axi_arready) ok = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    if (!ok) timeout_fail("ar_handshake");
    @(negedge clk);
    i_axi_arvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((wb_q.size() != 0 || rsp_q.size() != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) timeout_fail(name);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int seen;
    bit ok;
    i_reset       = 1'b1;
    i_axi_awvalid = 1'b0;
    i_axi_wvalid  = 1'b0;
    i_axi_arvalid = 1'b0;
    i_axi_awaddr  = '0;
    i_axi_wdata   = '0;
    i_axi_wstrb   = '0;
    i_axi_araddr  = '0;
    i_axi_bready  = 1'b1;
    i_axi_rready  = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    // Reset state
    #1;
    check("rst_ctrl", {o_wb_cyc, o_wb_stb, o_wb_we, o_axi_bvalid, o_axi_rvalid}, 0);
    check("rst_ready", {o_axi_awready, o_axi_wready, o_axi_arready}, 0);
    check("rst_resp", {o_axi_bresp, o_axi_rresp, o_axi_rdata}, 0);
    check("rst_wb_payload", {o_wb_addr, o_wb_data, o_wb_sel}, 0);
    @(negedge clk);

    // Write 0x10 / 0xDEADBEEF with cycle-accurate latency
    push_write(26'h4, 32'hDEAD_BEEF, 4'hF);
    axi_write(28'h000_0010, 32'hDEAD_BEEF, 4'hF);
    #1;
    check("wr_c1_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b11);
    @(negedge clk); #1;
    check("wr_c2_cyc_stb", {o_wb_cyc, o_wb_stb, o_axi_bvalid}, 3'b100);
    @(negedge clk); #1;
    check("wr_c3_bvalid_cyc", {o_axi_bvalid, o_wb_cyc}, 2'b10);
    drain("drain_write1");

    // Unaligned address with zero strobes
    push_write(26'h4, 32'h55AA_55AA, 4'h0);
    axi_write(28'h000_0013, 32'h55AA_55AA, 4'h0);
    drain("drain_wstrb0");

    // Read with 3 stall cycles: stb held 4 cycles with a stable address
    stall_cfg   = 3;
    slave_rdata = 32'h1234_5678;
    push_read(26'h2, 2'b00, 32'h1234_5678);
    axi_read(28'h000_0008);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_stb_addr", {o_wb_stb, o_wb_addr}, {1'b1, 26'h2});
      @(negedge clk);
    end
    #1;
    check("stall_stb_released", o_wb_stb, 0);
    drain("drain_stall_read");
    stall_cfg = 0;

    // Read terminated by err
    slave_err = 1'b1;
    push_read(26'h8, 2'b10, 32'h0);
    axi_read(28'h000_0020);
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 20) begin
      #1;
      if (o_axi_rvalid) ok = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    if (!ok) timeout_fail("err_rvalid");
    else check("err_cyc_low_in_resp", o_wb_cyc, 0);
    drain("drain_err_read");
    slave_err = 1'b0;

    // Back-pressured B with a read waiting behind it
    i_axi_bready = 1'b0;
    slave_rdata  = 32'h0BAD_F00D;
    push_write(26'hC, 32'hA5A5_A5A5, 4'hF);
    axi_write(28'h000_0030, 32'hA5A5_A5A5, 4'hF);
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 20) begin
      #1;
      if (o_axi_bvalid) ok = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    if (!ok) timeout_fail("bp_bvalid");
    push_read(26'h11, 2'b00, 32'h0BAD_F00D);
    fork
      axi_read(28'h000_0044);
      begin
        for (int k = 0; k < 5; k++) begin
          check("bp_bvalid_held", o_axi_bvalid, 1);
          check("bp_bus_quiet", {o_wb_cyc, o_wb_stb, o_axi_arready}, 0);
          @(negedge clk); #1;
        end
        i_axi_bready = 1'b1;
        @(negedge clk); #1;
        check("bp_after_b_ar_granted", {o_axi_bvalid, o_axi_arready, o_wb_stb}, 3'b010);
        @(negedge clk); #1;
        check("bp_next_stb", {o_wb_stb, o_wb_we, o_wb_addr}, {2'b10, 26'h11});
      end
    join
    drain("drain_backpressure");

    // Simultaneous AR and AW+W from reset: read, write, read, write
    pulse_reset();
    slave_rdata = 32'hCAFE_0001;
    push_read(26'h40, 2'b00, 32'hCAFE_0001);
    push_write(26'h80, 32'h1111_1111, 4'hF);
    push_read(26'h42, 2'b00, 32'hCAFE_0001);
    push_write(26'h81, 32'h2222_2222, 4'h3);
    fork
      begin
        axi_read(28'h000_0100);
        axi_read(28'h000_0108);
      end
      begin
        axi_write(28'h000_0200, 32'h1111_1111, 4'hF);
        axi_write(28'h000_0204, 32'h2222_2222, 4'h3);
      end
    join
    drain("drain_alternate");

    // Reset while the slave stalls the strobe: transaction dropped, no response
    stall_cfg = 1000;
    axi_write(28'h000_0040, 32'h7777_7777, 4'hF);
    #1;
    check("rst_mid_stalled", {o_wb_cyc, o_wb_stb}, 2'b11);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk); #1;
    check("rst_mid_dropped", {o_wb_cyc, o_wb_stb, o_axi_bvalid, o_axi_rvalid}, 0);
    i_reset   = 1'b0;
    stall_cfg = 0;
    seen      = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (o_axi_bvalid || o_axi_rvalid || o_wb_cyc) seen++;
    end
    check("rst_mid_no_response", seen, 0);
    check("queues_empty", {wb_q.size(), rsp_q.size()}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil2wbm.md
Name: axil2wbm

Overview:
- AXI4-Lite slave that converts each AXI read or write into a single pipelined Wishbone master transaction. This is the opposite direction of our Wishbone-to-AXI translator.
- Lets an AXI-side initiator reach Wishbone peripherals on the system (ui) clock domain, for example a DMA or a debug bridge.
- One transaction is in flight at a time. Reads and writes alternate when both are pending.

Parameters:
- C_AXI_ADDR_WIDTH, 28: AXI byte-address width.
- C_AXI_DATA_WIDTH, 32: AXI and Wishbone data width; must be 8·2^n.
- AW (derived), C_AXI_ADDR_WIDTH-$clog2(C_AXI_DATA_WIDTH/8): Wishbone word-address width.

Ports:
- i_clk / i_reset: in 1/1; system clock; sync active-high reset.
- i_axi_awvalid / o_axi_awready: in 1 / out 1; AW handshake.
- i_axi_awaddr: in C_AXI_ADDR_WIDTH; write byte address.
- i_axi_wvalid / o_axi_wready: in 1 / out 1; W handshake.
- i_axi_wdata: in DW; write data.
- i_axi_wstrb: in DW/8; byte strobes.
- o_axi_bvalid / i_axi_bready: out 1 / in 1; B handshake.
- o_axi_bresp: out 2; 00 OKAY, 10 SLVERR.
- i_axi_arvalid / o_axi_arready: in 1 / out 1; AR handshake.
- i_axi_araddr: in C_AXI_ADDR_WIDTH; read byte address.
- o_axi_rvalid / i_axi_rready: out 1 / in 1; R handshake.
- o_axi_rdata: out DW; read data.
- o_axi_rresp: out 2; 00 OKAY, 10 SLVERR.
- o_wb_cyc, o_wb_stb, o_wb_we: out 1 each; Wishbone master control.
- o_wb_addr: out AW; word address = axaddr[C_AXI_ADDR_WIDTH-1:$clog2(DW/8)].
- o_wb_data / o_wb_sel: out DW / DW/8; = wdata / wstrb.
- i_wb_stall, i_wb_ack, i_wb_err: in 1 each; slave responses.
- i_wb_data: in DW; read data.

Behaviour:
- Reset values:
  - cyc, stb, we, bvalid, rvalid, all readys: 0.
  - bresp, rresp, rdata, wb addr/data/sel: 0.
  - Arbitration flag: "last = write", so the first tie grants the read.
- FSM states:
  - IDLE → BUS on grant; cyc=stb=1 next cycle.
  - BUS: hold stb until !i_wb_stall, then stb=0 while cyc stays 1. Leave on ack/err → RESP; ack/err may arrive in the same cycle stb is accepted.
  - RESP: assert bvalid or rvalid; cyc=0 this cycle. Stay until ready, then → IDLE.
- Grant rules:
  - A write grant requires both AW and W to be held.
  - If only one kind is pending, grant it.
  - If both are pending, grant the kind not granted last.
- Response fields:
  - Any ack → resp 00; rdata captured from i_wb_data on ack.
  - err → resp 10; rdata=0.
  - ack and err in the same cycle: err wins.
- Latency (idle bus, zero stall, ack 1 cycle after stb): last AXI address/data handshake at cycle 0 → stb at cycle 1, ack at cycle 2, bvalid/rvalid at cycle 3.
- wstrb=0: still issued, with o_wb_sel=0.
- Address low bits are ignored (word aligned).
- Reset mid-transaction: next edge drops cyc/stb/valids; held requests are discarded; no response is emitted.
- Wishbone rules:
  - stb never asserts without cyc.
  - While stb=1 and stall=1, addr/data/sel/we are held.
  - Responses arriving while cyc=0 are ignored.

Optional Feature:
- Macro: AXIL2WBM_SKIDBUFFER_EN.
- Defined:
  - AW, W and AR each get a one-entry register; ready = entry empty.
  - A channel may be accepted while another transaction is in BUS/RESP, and AW and W may arrive on different cycles.
  - Entries free on grant.
- Undefined:
  - No storage. o_axi_arready, o_axi_awready and o_axi_wready are combinational, asserted only in IDLE for the granted kind.
  - AW and W are accepted in the same cycle, requiring both valid.
  - Same latency from acceptance.

Test Plan:
- Write awaddr=0x0000_0010, wdata=0xDEAD_BEEF, wstrb=0xF, slave ack after 1 cycle → o_wb_addr=0x4, we=1, sel=0xF, bresp=00; bvalid at stb+2.
- Read araddr=0x0000_0008, slave returns 0x1234_5678 with 3 stall cycles → stb held 4 cycles, addr stable at 0x2; rdata=0x1234_5678, rresp=00.
- Read where slave asserts err → rresp=10, rdata=0, cyc low in the RESP cycle.
- AR and AW+W valid together from reset, each repeated twice → WB order read, write, read, write.
- bready held low 5 cycles after ack → bvalid held, cyc=0, no new stb; bready=1 → next transaction starts the cycle after.
- i_reset pulsed while in BUS with stall=1 → cyc/stb=0 next cycle; no bvalid/rvalid ever for that request.
